// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam int REQ_IFETCH = 0;
    localparam int REQ_SLSU   = 1;
    localparam int REQ_VLSU   = 2;

    localparam int REQ_AW = 32;
    localparam int REQ_DW = 32;

    typedef struct packed {
        logic                  we;
        logic [REQ_AW-1:0]     addr;
        logic [REQ_DW-1:0]     wdata;
        logic [REQ_DW/8-1:0]   wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit scanning from ptr upward, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);

    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port; one outstanding transaction,
// registered request/response paths and a watchdog that turns a hung memory into an error response.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_we,
    input  logic [NUM_REQ*AW-1:0]   req_addr,
    input  logic [NUM_REQ*DW-1:0]   req_wdata,
    input  logic [NUM_REQ*DW/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [DW-1:0]           rsp_rdata,
    output logic                    rsp_err,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    output logic [DW/8-1:0]         mem_wstrb,
    input  logic                    mem_rsp_valid,
    input  logic [DW-1:0]           mem_rsp_rdata
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    arb_state_e    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_q;
    logic [CW-1:0] cnt;

    logic               found;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [IW-1:0]      gnt_idx;
    logic               expired;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .found (found),
        .grant (gnt_oh),
        .idx   (gnt_idx)
    );

    assign req_ready     = (state == IDLE && found) ? gnt_oh : '0;
    assign mem_req_valid = (state == ISSUE);
    assign expired       = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            cnt       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        mem_we    <= req_we[gnt_idx];
                        mem_addr  <= req_addr[gnt_idx*AW +: AW];
                        mem_wdata <= req_wdata[gnt_idx*DW +: DW];
                        mem_wstrb <= req_wstrb[gnt_idx*SW +: SW];
                        grant_q   <= gnt_idx;
                        rr_ptr    <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        cnt       <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // An accept on the expiry cycle still counts: the memory owns the request now.
                    if (mem_req_ready) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else if (expired) begin
                        rsp_valid <= NUM_REQ'(1) << grant_q;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        rsp_valid <= NUM_REQ'(1) << grant_q;
                        rsp_rdata <= mem_rsp_rdata;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end else if (expired) begin
                        rsp_valid <= NUM_REQ'(1) << grant_q;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 3;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [N*4-1:0]  req_wstrb;
    logic [31:0]     rsp_rdata, mem_addr, mem_wdata, mem_rsp_rdata;
    logic            rsp_err, mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [3:0]      mem_wstrb;

    int       tests = 0;
    int       fails = 0;
    int       rr_model = 0;
    mem_req_t reqs [N];

    mem_port_arbiter #(.NUM_REQ(N), .AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Spec rule: first requesting index scanning from the pointer, modulo N.
    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int i = 0; i < N; i++)
            if (m[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < N; i++)
            reqs[i] = '{we: 1'($urandom), addr: $urandom, wdata: $urandom, wstrb: 4'($urandom)};
    endtask

    task automatic drive_fields();
        for (int i = 0; i < N; i++) begin
            req_we[i]           = reqs[i].we;
            req_addr[i*32 +: 32]  = reqs[i].addr;
            req_wdata[i*32 +: 32] = reqs[i].wdata;
            req_wstrb[i*4 +: 4]   = reqs[i].wstrb;
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"},   rsp_err, 0);
        chk({tag, "_mem_valid"}, mem_req_valid, 0);
        chk({tag, "_mem_we"},    mem_we, 0);
        chk({tag, "_mem_addr"},  mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
    endtask

    // One transaction: accept, rdy_dly stall cycles in ISSUE, response rsp_dly cycles into WAIT
    // (negative or >= TO means none). abort_w >= 0 asserts reset at that WAIT cycle.
    task automatic do_txn(input logic [N-1:0] mask, input int rdy_dly, input int rsp_dly,
                          input logic [31:0] rdata, input int abort_w);
        int   win, last;
        logic err;
        win = pick(mask, rr_model);
        @(negedge clk);
        drive_fields();
        req_valid = mask; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        chk("accept_rsp_quiet", rsp_valid, 0);
        chk("accept_req_ready", req_ready, 64'(1) << win);
        chk("accept_mem_valid", mem_req_valid, 0);
        rr_model = (win + 1) % N;
        for (int d = 0; d <= rdy_dly; d++) begin
            @(negedge clk);
            req_valid = 3'($urandom); mem_req_ready = (d == rdy_dly);
            mem_rsp_valid = 1'($urandom); mem_rsp_rdata = $urandom;
            #1;
            chk("issue_valid",     mem_req_valid, 1);
            chk("issue_req_ready", req_ready, 0);
            chk("issue_rsp_valid", rsp_valid, 0);
            chk("issue_we",        mem_we, reqs[win].we);
            chk("issue_addr",      mem_addr, reqs[win].addr);
            chk("issue_wdata",     mem_wdata, reqs[win].wdata);
            chk("issue_wstrb",     mem_wstrb, reqs[win].wstrb);
        end
        err  = (rsp_dly < 0) || (rsp_dly > TO - 1);
        last = err ? TO - 1 : rsp_dly;
        for (int w = 0; w <= last; w++) begin
            @(negedge clk);
            mem_req_ready = 1'b0; req_valid = 3'($urandom);
            if (w == abort_w) begin
                rst = 1'b1; req_valid = '0; mem_rsp_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = $urandom;
                #1;
                chk_idle_zero("abort");
                @(negedge clk);
                mem_rsp_valid = 1'b0;
                #1;
                chk("abort_late_rsp", rsp_valid, 0);
                chk("abort_mem_valid", mem_req_valid, 0);
                rr_model = 0;
                return;
            end
            mem_rsp_valid = (w == rsp_dly);
            mem_rsp_rdata = (w == rsp_dly) ? rdata : $urandom;
            #1;
            chk("wait_mem_valid", mem_req_valid, 0);
            chk("wait_rsp_valid", rsp_valid, 0);
            chk("wait_req_ready", req_ready, 0);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0; req_valid = '0;
        #1;
        chk("rsp_valid", rsp_valid, 64'(1) << win);
        chk("rsp_err",   rsp_err, err);
        chk("rsp_rdata", rsp_rdata, err ? 32'd0 : rdata);
        // Stray response while idle must be ignored and response fields must hold.
        @(negedge clk);
        mem_rsp_valid = 1'($urandom); mem_rsp_rdata = $urandom;
        #1;
        chk("after_rsp_valid", rsp_valid, 0);
        chk("hold_rdata",      rsp_rdata, err ? 32'd0 : rdata);
        chk("hold_err",        rsp_err, err);
        chk("after_mem_valid", mem_req_valid, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b0;

        // Fairness from rr_ptr=0: grants rotate 0,1,2 three times.
        for (int i = 0; i < 9; i++) begin
            rand_fields();
            do_txn(3'b111, $urandom_range(0, 2), $urandom_range(0, 3), $urandom, -1);
        end

        // Single read at minimum latency.
        rand_fields();
        reqs[REQ_IFETCH] = '{we: 1'b0, addr: 32'h100, wdata: 32'h0, wstrb: 4'h0};
        do_txn(3'b001, 0, 0, 32'hDEADBEEF, -1);

        // Write from the scalar LSU with 3 stall cycles.
        rand_fields();
        reqs[REQ_SLSU] = '{we: 1'b1, addr: 32'h2004, wdata: 32'h12345678, wstrb: 4'b0011};
        do_txn(3'b010, 3, 1, $urandom, -1);

        // Response on the expiry cycle wins; then a real timeout.
        rand_fields();
        do_txn(3'b100, 1, TO - 1, 32'hCAFEF00D, -1);
        rand_fields();
        do_txn(3'b101, 0, -1, 32'h0, -1);

        // Reset mid-WAIT, then 3'b110 must go to requester 1.
        rand_fields();
        do_txn(3'b011, 0, -1, 32'h0, 2);
        rand_fields();
        do_txn(3'b110, 0, 0, 32'h55AA55AA, -1);

        for (int i = 0; i < 25; i++) begin
            logic [N-1:0] m;
            m = 3'($urandom_range(1, 7));
            rand_fields();
            do_txn(m, $urandom_range(0, 5), $urandom_range(0, 20), $urandom, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port of rv32im_vector among three requesters: instruction fetch (0), scalar load/store unit (1) and vector load/store unit (2).
- Sits between the core's memory clients and main_memory.
- Round-robin arbitration, one outstanding transaction, registered request and response paths.
- A watchdog timeout returns an error response so a hung memory cannot deadlock the core.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = ifetch, 1 = scalar LSU, 2 = vector LSU.
- AW, 32, address width.
- DW, 32, data width; strobe width is DW/8.
- TIMEOUT, 1024, maximum cycles in WAIT before an error response; must be ≥ 2.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted (one-hot pulse).
- req_we  in  NUM_REQ  1 = write.
- req_addr  in  NUM_REQ*AW  packed byte addresses.
- req_wdata  in  NUM_REQ*DW  packed write data.
- req_wstrb  in  NUM_REQ*DW/8  packed byte strobes.
- rsp_valid  out  NUM_REQ  per-requester response pulse.
- rsp_rdata  out  DW  read data, shared; qualified by rsp_valid.
- rsp_err  out  1  timeout error, qualified by rsp_valid.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_wstrb  out  DW/8  memory byte strobes.
- mem_rsp_valid  in  1  memory response, for both reads and writes.
- mem_rsp_rdata  in  DW  memory read data.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant_q=0, timeout counter=0. All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb.
- Reset has priority over every other event. Reset mid-transaction abandons the transaction: no rsp_valid is issued, and a late mem_rsp_valid is ignored.
- FSM has three states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in that cycle; that cycle is the handshake.
  - Register we/addr/wdata/wstrb to the mem_* outputs and store grant_q=winner.
  - rr_ptr <= (winner+1) mod NUM_REQ. Go to ISSUE.
  - If no req_valid is set, stay in IDLE and leave rr_ptr unchanged.
- ISSUE:
  - mem_req_valid=1, with mem_* fields held stable.
  - On mem_req_ready: drop mem_req_valid next cycle, clear the counter, go to WAIT.
  - The timeout counter also runs in ISSUE. On expiry, take the same path as a WAIT timeout.
- WAIT:
  - Counter increments every cycle.
  - On mem_rsp_valid: next cycle rsp_valid[grant_q]=1, rsp_rdata=mem_rsp_rdata (registered), rsp_err=0. Go to IDLE.
  - When the counter reaches TIMEOUT-1 with no response: next cycle rsp_valid[grant_q]=1, rsp_rdata=0, rsp_err=1. Go to IDLE.
  - A response and expiry in the same cycle: the response wins, rsp_err=0.
- rsp_valid is a one-cycle pulse. Requesters must always accept it; there is no back-pressure.
- rsp_rdata and rsp_err hold their value until the next response.
- mem_rsp_valid outside WAIT is ignored. This covers a stray response and a late response after a timeout.
- req_ready is never asserted outside IDLE. At most one bit of req_ready and at most one bit of rsp_valid is set in any cycle.
- Minimum latency (mem_req_ready and mem_rsp_valid each after one cycle):
  - accept at T, mem_req_valid at T+1, response at T+2, rsp_valid at T+3, next accept at T+3.
  - Back-to-back throughput is one transaction per 3 cycles.
- No address decoding, alignment checking or strobe modification; fields pass through unchanged.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef arb_state_e {IDLE, ISSUE, WAIT};
  - requester index constants REQ_IFETCH=0, REQ_SLSU=1, REQ_VLSU=2;
  - a packed mem_req_t struct (we, addr, wdata, wstrb).
- One sub-module, rr_pick: combinational round-robin priority picker taking (valid vector, rr_ptr) and returning (found, one-hot grant, index).

Test Plan:
- Single read: rst for 2 cycles, then req_valid=3'b001, addr=0x100; memory returns 0xDEADBEEF one cycle after mem_req_ready. Expect req_ready=001, then mem_addr=0x100 with mem_we=0, then rsp_valid=001, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Fairness: req_valid held at 3'b111 for 9 grants. Expect grant order 0,1,2,0,1,2,0,1,2, with rsp_valid one-hot and matching the grant order.
- Write path: requester 1 writes addr=0x2004, wdata=0x12345678, wstrb=4'b0011. Expect identical mem_* fields, mem_req_valid held for 3 stall cycles of mem_req_ready=0, then rsp_valid=010.
- Timeout: TIMEOUT=16, memory never responds. Expect rsp_valid[grant]=1, rsp_err=1, rsp_rdata=0 exactly 16 cycles after entering WAIT. A mem_rsp_valid injected afterwards produces no rsp_valid.
- Reset mid-operation: assert rst in WAIT, then deliver mem_rsp_valid the following cycle. Expect no rsp_valid, all outputs 0 and rr_ptr=0, so the next request from 3'b110 is granted to requester 1.
